// File: rtl/compositor_pkg.sv
// Shared helpers for the layer compositor: colour constants sized to the pixel
// width, the layer-index width helper and the per-pixel opacity rule.
package compositor_pkg;

    // Widest pixel the helpers handle; callers zero-extend narrower pixels.
    localparam int unsigned MAX_COLOR_W = 32;

    typedef logic [MAX_COLOR_W-1:0] color_t;

    // All-ones within a w-bit colour field (white), zero above it.
    function automatic color_t color_white(int unsigned w);
        return {MAX_COLOR_W{1'b1}} >> (MAX_COLOR_W - w);
    endfunction

    // All-zeros within a w-bit colour field (black).
    function automatic color_t color_black(int unsigned w);
        return {MAX_COLOR_W{1'b0}} & color_white(w);
    endfunction

    // Bits needed to index n layers (at least one bit).
    function automatic int unsigned layer_idx_w(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Black and white are the transparent keys; a disabled layer is never opaque.
    function automatic logic opaque(logic en, color_t pix, int unsigned w);
        color_t field;
        field = pix & color_white(w);
        return en && (field != color_black(w)) && (field != color_white(w));
    endfunction

endpackage

// File: rtl/pix_opaque.sv
// One compositor layer's first pipeline stage: registered opacity flag and
// the matching one-cycle delay of the pixel data.
module pix_opaque
    import compositor_pkg::*;
#(
    parameter int unsigned COLOR_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [COLOR_W-1:0] pix,
    output logic               opq,
    output logic [COLOR_W-1:0] pix_q
);

    color_t pix_ext;

    // Zero-extend the pixel to the width the package helpers work on.
    always_comb begin
        pix_ext              = '0;
        pix_ext[COLOR_W-1:0] = pix;
    end

    // Register the opacity decision alongside the pixel it belongs to.
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opq   <= 1'b0;
            pix_q <= '0;
        end else begin
            opq   <= opaque(en, pix_ext, COLOR_W);
            pix_q <= pix;
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// N-layer priority pixel compositor with a frame-synchronised full-screen
// overlay and per-frame layer-0/layer-1 overlap reporting.
// Optional feature: define OVERLAY_BLINK_EN to blink the overlay with a
// half-period of BLINK_FRAMES frames; otherwise the overlay is steady.
module layer_compositor
    import compositor_pkg::*;
#(
    parameter int unsigned NUM_LAYERS   = 3,
    parameter int unsigned COLOR_W      = 12,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          video_on,
    input  logic                          frame_start,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_pix,
    input  logic [NUM_LAYERS-1:0]         layer_en,
    input  logic [COLOR_W-1:0]            overlay_pix,
    input  logic                          overlay_set,
    input  logic                          overlay_clr,
    output logic [COLOR_W-1:0]            vga_out,
    output logic [$clog2(NUM_LAYERS)-1:0] layer_sel,
    output logic                          overlay_act,
    output logic                          collision
);

    localparam int unsigned SEL_W = layer_idx_w(NUM_LAYERS);

    logic [NUM_LAYERS-1:0]         opq_q;
    logic [NUM_LAYERS*COLOR_W-1:0] pix_q;
    logic                          vid_q;
    logic [COLOR_W-1:0]            ovl_pix_q;
    logic                          ovl_pend;
    logic                          ovl_show;
    logic                          overlap_flag;
    logic                          overlap_hit;
    logic [SEL_W-1:0]              sel_idx;
    logic [COLOR_W-1:0]            sel_pix;

    // Stage 1 per layer; the background layer is forced enabled.
    for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
        pix_opaque #(.COLOR_W(COLOR_W)) u_opq (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (layer_en[k] || (k == NUM_LAYERS - 1)),
            .pix   (layer_pix[k*COLOR_W +: COLOR_W]),
            .opq   (opq_q[k]),
            .pix_q (pix_q[k*COLOR_W +: COLOR_W])
        );
    end

    // Stage 1 for the signals shared by all layers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vid_q     <= 1'b0;
            ovl_pix_q <= '0;
        end else begin
            vid_q     <= video_on;
            ovl_pix_q <= overlay_pix;
        end
    end

    // Pending overlay request (clear beats set) and its frame-aligned apply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovl_pend    <= 1'b0;
            overlay_act <= 1'b0;
        end else begin
            if (overlay_clr)      ovl_pend <= 1'b0;
            else if (overlay_set) ovl_pend <= 1'b1;
            if (frame_start)      overlay_act <= ovl_pend;
        end
    end

`ifdef OVERLAY_BLINK_EN
    localparam int unsigned CNT_W = layer_idx_w(2 * BLINK_FRAMES);

    logic [CNT_W-1:0] blink_cnt;

    // Count frames since the overlay came on, wrapping every full blink period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
        end else if (frame_start) begin
            if (overlay_act && ovl_pend)
                blink_cnt <= (blink_cnt == CNT_W'(2 * BLINK_FRAMES - 1)) ? '0 : blink_cnt + 1'b1;
            else
                blink_cnt <= '0;
        end
    end

    assign ovl_show = overlay_act && (blink_cnt < CNT_W'(BLINK_FRAMES));
`else
    assign ovl_show = overlay_act;
`endif

    // Lowest-index opaque layer wins; with none opaque the background falls through.
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        sel_idx = SEL_W'(NUM_LAYERS - 1);
        sel_pix = pix_q[(NUM_LAYERS-1)*COLOR_W +: COLOR_W];
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (opq_q[i]) begin
                sel_idx = SEL_W'(i);
                sel_pix = pix_q[i*COLOR_W +: COLOR_W];
            end
        end
    end

    // Stage 2: blank outside the active area, overlay over everything when shown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_out   <= '0;
            layer_sel <= '0;
        end else if (!vid_q) begin
            vga_out   <= '0;
            layer_sel <= '0;
        end else if (ovl_show) begin
            vga_out   <= ovl_pix_q;
            layer_sel <= '0;
        end else begin
            vga_out   <= sel_pix;
            layer_sel <= sel_idx;
        end
    end

    assign overlap_hit = vid_q && opq_q[0] && opq_q[1];

    // Sticky per-frame overlap; reported and restarted at each frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overlap_flag <= 1'b0;
            collision    <= 1'b0;
        end else if (frame_start) begin
            collision    <= overlap_flag;
            overlap_flag <= overlap_hit;
        end else begin
            collision    <= 1'b0;
            overlap_flag <= overlap_flag || overlap_hit;
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor (3 layers, RGB444, blink half-period 2).
module tb_layer_compositor;

    localparam int NL = 3;
    localparam int CW = 12;
    localparam int BF = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             video_on;
    logic             frame_start;
    logic [NL*CW-1:0] layer_pix;
    logic [NL-1:0]    layer_en;
    logic [CW-1:0]    overlay_pix;
    logic             overlay_set;
    logic             overlay_clr;
    logic [CW-1:0]    vga_out;
    logic [1:0]       layer_sel;
    logic             overlay_act;
    logic             collision;

    layer_compositor #(.NUM_LAYERS(NL), .COLOR_W(CW), .BLINK_FRAMES(BF)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .video_on    (video_on),
        .frame_start (frame_start),
        .layer_pix   (layer_pix),
        .layer_en    (layer_en),
        .overlay_pix (overlay_pix),
        .overlay_set (overlay_set),
        .overlay_clr (overlay_clr),
        .vga_out     (vga_out),
        .layer_sel   (layer_sel),
        .overlay_act (overlay_act),
        .collision   (collision)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NL*CW-1:0] pix;
        logic [NL-1:0]    en;
        logic             vid;
        logic             fs;
        logic             set;
        logic             clr;
        logic [CW-1:0]    opix;
    } stim_t;

    int total = 0;
    int bad   = 0;

    // Reference model state: what the spec says is held between cycles.
    stim_t prev;          // inputs presented one cycle before the current one
    bit    m_pend, m_act, m_flag, m_coll;
    int    m_frames;      // frames elapsed since the overlay came on
    int    obs_ovl, obs_coll;
    logic [NL*CW-1:0] base_pix;
    logic [NL-1:0]    base_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit opq(stim_t s, int k);
        logic [CW-1:0] p;
        p = s.pix[k*CW +: CW];
        return s.en[k] && (p != 12'h000) && (p != 12'hFFF);
    endfunction

    // Expected {layer_sel, vga_out} for a pixel, by the priority rules.
    function automatic logic [13:0] composite(stim_t s, bit show);
        if (!s.vid) return '0;
        if (show) return {2'd0, s.opix};
        for (int k = 0; k < NL - 1; k++)
            if (opq(s, k)) return {2'(k), s.pix[k*CW +: CW]};
        return {2'd2, s.pix[(NL-1)*CW +: CW]};
    endfunction

    function automatic stim_t zero_stim();
        stim_t s;
        s.pix = '0; s.en = '0; s.vid = 1'b0; s.fs = 1'b0;
        s.set = 1'b0; s.clr = 1'b0; s.opix = '0;
        return s;
    endfunction

    function automatic logic [CW-1:0] rand_color();
        case ($urandom_range(0, 3))
            0:       return 12'h000;
            1:       return 12'hFFF;
            default: return CW'($urandom);
        endcase
    endfunction

    // Present one cycle of stimulus, clock it, and compare with the model.
    task automatic step(input stim_t s);
        logic [13:0] exp;
        bit          show;
        layer_pix   = s.pix;
        layer_en    = s.en;
        video_on    = s.vid;
        frame_start = s.fs;
        overlay_set = s.set;
        overlay_clr = s.clr;
        overlay_pix = s.opix;
        @(posedge clk);
        #1;
`ifdef OVERLAY_BLINK_EN
        show = m_act && ((m_frames % (2 * BF)) < BF);
`else
        show = m_act;
`endif
        exp = composite(prev, show);
        if (s.fs) begin
            m_coll   = m_flag;
            m_flag   = prev.vid && opq(prev, 0) && opq(prev, 1);
            m_frames = (m_act && m_pend) ? m_frames + 1 : 0;
            m_act    = m_pend;
        end else begin
            m_coll = 1'b0;
            m_flag = m_flag || (prev.vid && opq(prev, 0) && opq(prev, 1));
        end
        if (s.clr)      m_pend = 1'b0;
        else if (s.set) m_pend = 1'b1;
        prev = s;
        check("vga_out", 32'(vga_out), 32'(exp[11:0]));
        check("layer_sel", 32'(layer_sel), 32'(exp[13:12]));
        check("overlay_act", 32'(overlay_act), 32'(m_act));
        check("collision", 32'(collision), 32'(m_coll));
        if (vga_out == 12'hABC) obs_ovl++;
        if (collision) obs_coll++;
    endtask

    // Asynchronous reset between edges; outputs must clear immediately.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_vga", 32'(vga_out), 32'h0);
        check("rst_sel", 32'(layer_sel), 32'h0);
        check("rst_act", 32'(overlay_act), 32'h0);
        check("rst_coll", 32'(collision), 32'h0);
        m_pend = 0; m_act = 0; m_flag = 0; m_coll = 0; m_frames = 0;
        prev = zero_stim();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One frame: frame_start on cycle 0, active video on cycles 2..len-3.
    task automatic run_frame(input int len, input bit rnd, input int set_at,
                             input int clr_at, input int hit_at, input int rst_at);
        stim_t s;
        obs_ovl  = 0;
        obs_coll = 0;
        for (int c = 0; c < len; c++) begin
            if (c == rst_at) do_reset();
            s      = zero_stim();
            s.fs   = (c == 0);
            s.vid  = (c >= 2) && (c < len - 2);
            s.opix = 12'hABC;
            s.pix  = base_pix;
            s.en   = base_en;
            if (rnd) begin
                for (int k = 0; k < NL; k++) s.pix[k*CW +: CW] = rand_color();
                s.en   = NL'($urandom);
                s.vid  = s.vid && ($urandom_range(0, 7) != 0);
                s.set  = ($urandom_range(0, 19) == 0);
                s.clr  = ($urandom_range(0, 39) == 0);
                s.opix = CW'($urandom);
            end
            if (c == set_at) s.set = 1'b1;
            if (c == clr_at) s.clr = 1'b1;
            if (c == hit_at) begin
                s.pix[0*CW +: CW] = 12'h0F0;
                s.pix[1*CW +: CW] = 12'hF00;
            end
            step(s);
        end
    endtask

    task automatic pix_cycles(input logic [NL*CW-1:0] pix, input logic [NL-1:0] en,
                              input bit vid, input int n);
        stim_t s;
        s = zero_stim();
        s.pix = pix; s.en = en; s.vid = vid;
        for (int i = 0; i < n; i++) step(s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        prev  = zero_stim();
        layer_pix = '0; layer_en = '0; video_on = 0; frame_start = 0;
        overlay_pix = '0; overlay_set = 0; overlay_clr = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Priority select and transparency keys.
        pix_cycles({12'h333, 12'hF00, 12'h0F0}, 3'b111, 1, 2);
        check("prio_vga", 32'(vga_out), 32'h0F0);
        check("prio_sel", 32'(layer_sel), 32'h0);
        pix_cycles({12'hFFF, 12'hFFF, 12'h000}, 3'b111, 1, 2);
        check("bg_vga", 32'(vga_out), 32'hFFF);
        check("bg_sel", 32'(layer_sel), 32'h2);
        pix_cycles({12'hFFF, 12'hFFF, 12'h0F0}, 3'b110, 1, 2);
        check("dis_vga", 32'(vga_out), 32'hFFF);
        pix_cycles({12'h333, 12'hF00, 12'h0F0}, 3'b111, 0, 2);
        check("blank_vga", 32'(vga_out), 32'h000);
        pix_cycles({12'h333, 12'hF00, 12'h0F0}, 3'b111, 1, 3);
        do_reset();

        // Overlay: request mid-frame, applied only from the next frame, then blink.
        base_pix = {12'h333, 12'h000, 12'h000};
        base_en  = 3'b111;
        run_frame(16, 0, -1, -1, -1, -1);
        run_frame(16, 0, 6, -1, -1, -1);
        check("ovl_wait", 32'(obs_ovl), 32'd0);
        for (int f = 0; f < 6; f++) begin
            run_frame(16, 0, -1, -1, -1, -1);
`ifdef OVERLAY_BLINK_EN
            check("ovl_blink", 32'(obs_ovl), ((f % 4) < 2) ? 32'd12 : 32'd0);
`else
            check("ovl_steady", 32'(obs_ovl), 32'd12);
`endif
        end
        // Same-cycle set and clear: clear wins, overlay stays off.
        run_frame(16, 0, 5, 5, -1, -1);
        run_frame(16, 0, 5, 5, -1, -1);
        check("setclr_off", 32'(obs_ovl), 32'd0);
        run_frame(16, 0, -1, -1, -1, -1);
        check("setclr_next", 32'(obs_ovl), 32'd0);

        // Collision: one overlapping pixel in frame N, none in N+1.
        run_frame(16, 0, -1, -1, 7, -1);
        run_frame(16, 0, -1, -1, -1, -1);
        check("coll_pulse", 32'(obs_coll), 32'd1);
        run_frame(16, 0, -1, -1, -1, -1);
        check("coll_clear", 32'(obs_coll), 32'd0);

        // Randomized frames with one mid-frame reset.
        for (int f = 0; f < 40; f++) begin
            int len;
            len = $urandom_range(8, 30);
            run_frame(len, 1, -1, -1, -1, (f == 20) ? len / 2 : -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
